// File: rtl/mmio_ctrl_ws.sv
// -----------------------------------------------------------------------------
// mmio_ctrl_ws
//
// MMIO slot controller with wait-state support. It sits between the FPro bus
// master and the I/O slot cores. A word address is split into a slot index
// and a register index. The selected slot receives a single-cycle strobe. The
// controller then waits for that slot's ready handshake, or for a timeout. It
// finishes with a one-cycle completion pulse and registered read data.
// Unmapped addresses and silent slots end with an error response.
//
// Ports
//   clk, reset        system clock, asynchronous active-high reset
//   mmio_cs/wr/rd     bus request (a request with both rd and wr is a write)
//   mmio_addr         word address: {high bits, slot, reg}
//   mmio_wr_data      write data from the bus
//   mmio_rd_data      registered read data, valid with mmio_ready
//   mmio_ready        one-cycle completion pulse
//   mmio_err          error flag, meaningful only with mmio_ready
//   slot_cs/rd/wr     one-hot strobes, high for the single STRB cycle
//   slot_reg_addr     latched register index, broadcast to all slots
//   slot_wr_data      latched write data, broadcast to all slots
//   slot_rd_data      per-slot read data, slot s at [s*32 +: 32]
//   slot_ready        per-slot completion; only the selected bit is looked at
//   err_cnt           saturating count of error responses
// -----------------------------------------------------------------------------
module mmio_ctrl_ws #(
  parameter int          N_SLOT   = 64,
  parameter int          REG_W    = 5,
  parameter int          ADDR_W   = 21,
  parameter int          TO_CYC   = 255,
  parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mmio_cs,
  input  logic                 mmio_wr,
  input  logic                 mmio_rd,
  input  logic [ADDR_W-1:0]    mmio_addr,
  input  logic [31:0]          mmio_wr_data,
  output logic [31:0]          mmio_rd_data,
  output logic                 mmio_ready,
  output logic                 mmio_err,
  output logic [N_SLOT-1:0]    slot_cs,
  output logic [N_SLOT-1:0]    slot_rd,
  output logic [N_SLOT-1:0]    slot_wr,
  output logic [REG_W-1:0]     slot_reg_addr,
  output logic [31:0]          slot_wr_data,
  input  logic [N_SLOT*32-1:0] slot_rd_data,
  input  logic [N_SLOT-1:0]    slot_ready,
  output logic [7:0]           err_cnt
);

  // A single-slot build still keeps one slot bit so the decode stays regular;
  // that bit must then be zero or the access is a decode error.
  localparam int SLOT_W = (N_SLOT > 1) ? $clog2(N_SLOT) : 1;
  localparam int DEC_W  = REG_W + SLOT_W;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STRB,
    S_WAIT,
    S_RESP
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t             r_state;
  logic [SLOT_W-1:0]  r_slot;
  logic [REG_W-1:0]   r_reg;
  logic               r_wr;
  logic [31:0]        r_wr_data;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_err;
  logic [31:0]        r_rd_data;
  logic [7:0]         r_err_cnt;

  // ---------------------------------------------------------------------------
  // Address decode of the incoming request
  // ---------------------------------------------------------------------------
  logic [REG_W-1:0]   w_reg;
  logic [SLOT_W-1:0]  w_slot;
  logic               w_hi_set;
  logic               w_slot_oob;
  logic               w_dec_err;
  logic               w_req;

  assign w_reg  = mmio_addr[REG_W-1:0];
  assign w_slot = mmio_addr[REG_W +: SLOT_W];

  generate
    if (ADDR_W > DEC_W) begin : g_hi_bits
      assign w_hi_set = |mmio_addr[ADDR_W-1:DEC_W];
    end else begin : g_no_hi_bits
      assign w_hi_set = 1'b0;
    end

    // Only a non-power-of-two slot count leaves unmapped slot indices.
    if ((1 << SLOT_W) > N_SLOT) begin : g_slot_range
      assign w_slot_oob = ({1'b0, w_slot} >= (SLOT_W + 1)'(N_SLOT));
    end else begin : g_slot_full
      assign w_slot_oob = 1'b0;
    end
  endgenerate

  assign w_dec_err = w_hi_set | w_slot_oob;
  assign w_req     = mmio_cs & (mmio_rd | mmio_wr);

  // ---------------------------------------------------------------------------
  // Selected-slot views: ready bit, read data and one-hot select
  // ---------------------------------------------------------------------------
  logic               w_sel_ready;
  logic [31:0]        w_sel_data;
  logic [N_SLOT-1:0]  w_slot_1h;

  assign w_sel_ready = slot_ready[r_slot];
  assign w_sel_data  = slot_rd_data[{r_slot, 5'b00000} +: 32];

  always_comb begin
    w_slot_1h = '0;
    for (int i = 0; i < N_SLOT; i++) begin
      w_slot_1h[i] = (r_slot == SLOT_W'(i));
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and control decode
  // ---------------------------------------------------------------------------
  state_t       w_state_nxt;
  logic         w_accept;     // latch slot/reg/op/data from the bus
  logic         w_cnt_clr;
  logic         w_cnt_inc;
  logic         w_resp_go;    // entering RESP on this edge
  logic         w_resp_err;   // error flag for the response being entered
  logic         w_rd_load;    // update read data on this edge
  logic [31:0]  w_rd_nxt;
  logic         w_timeout;

  // The counter reaches TO_CYC on the edge that leaves the last WAIT cycle.
  assign w_timeout = (r_cnt == CNT_W'(TO_CYC - 1));

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; an unassigned path in combinational logic infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_resp_go   = 1'b0;
    w_resp_err  = 1'b0;
    w_rd_load   = 1'b0;
    w_rd_nxt    = ERR_DATA;

    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_accept = 1'b1;
          if (w_dec_err) begin
            // Unmapped address: answer at once, no strobe to any slot.
            w_state_nxt = S_RESP;
            w_resp_go   = 1'b1;
            w_resp_err  = 1'b1;
            w_rd_load   = ~mmio_wr;
          end else begin
            w_state_nxt = S_STRB;
          end
        end
      end

      S_STRB: begin
        if (w_sel_ready) begin
          w_state_nxt = S_RESP;
          w_resp_go   = 1'b1;
          w_rd_load   = ~r_wr;
          w_rd_nxt    = w_sel_data;
        end else begin
          w_state_nxt = S_WAIT;
          w_cnt_clr   = 1'b1;
        end
      end

      S_WAIT: begin
        // Ready wins over a timeout that falls in the same cycle.
        if (w_sel_ready) begin
          w_state_nxt = S_RESP;
          w_resp_go   = 1'b1;
          w_rd_load   = ~r_wr;
          w_rd_nxt    = w_sel_data;
        end else begin
          w_cnt_inc = 1'b1;
          if (w_timeout) begin
            w_state_nxt = S_RESP;
            w_resp_go   = 1'b1;
            w_resp_err  = 1'b1;
            w_rd_load   = ~r_wr;
          end
        end
      end

      S_RESP: begin
        // Any request seen here is dropped; IDLE is the only accepting state.
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_slot    <= '0;
      r_reg     <= '0;
      r_wr      <= 1'b0;
      r_wr_data <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_rd_data <= '0;
      r_err_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_accept) begin
        r_slot    <= w_slot;
        r_reg     <= w_reg;
        r_wr      <= mmio_wr;
        r_wr_data <= mmio_wr_data;
      end

      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (w_resp_go) begin
        r_err <= w_resp_err;
      end

      if (w_rd_load) begin
        r_rd_data <= w_rd_nxt;
      end

      if (w_resp_go && w_resp_err && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Strobes decode straight from the state register, so an asynchronous reset
  // drops them in the same instant.
  assign slot_cs = (r_state == S_STRB) ? w_slot_1h : '0;
  assign slot_rd = (r_state == S_STRB && !r_wr) ? w_slot_1h : '0;
  assign slot_wr = (r_state == S_STRB &&  r_wr) ? w_slot_1h : '0;

  assign slot_reg_addr = r_reg;
  assign slot_wr_data  = r_wr_data;

  assign mmio_ready   = (r_state == S_RESP);
  assign mmio_err     = (r_state == S_RESP) & r_err;
  assign mmio_rd_data = r_rd_data;
  assign err_cnt      = r_err_cnt;

endmodule

// File: doc/mmio_ctrl_ws.md
# mmio_ctrl_ws

Parametrised MMIO slot controller with wait-state support. It sits between the FPro bus master and the I/O slot cores. It decodes a word address into a slot index and a register index, and issues a single-cycle strobe to the selected slot. It then waits for that slot's ready handshake and returns registered read data with a completion pulse. Accesses to unmapped slots and to slots that never respond are terminated with an error response.

## Interface
Parameters:
- N_SLOT, 64, number of slots; SLOT_W = $clog2(N_SLOT)
- REG_W, 5, register-index bits per slot
- ADDR_W, 21, bus word-address width; must be at least REG_W+SLOT_W
- TO_CYC, 255, wait cycles before timeout (1..2^16-1)
- ERR_DATA, 32'h0000_0000, read data returned on any error

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- mmio_cs  in  1  bus request qualifier
- mmio_wr  in  1  write request
- mmio_rd  in  1  read request
- mmio_addr  in  ADDR_W  word address
- mmio_wr_data  in  32  write data
- mmio_rd_data  out  32  registered read data
- mmio_ready  out  1  one-cycle completion pulse
- mmio_err  out  1  error flag, valid only with mmio_ready
- slot_cs  out  N_SLOT  one-hot slot select (strobe)
- slot_rd  out  N_SLOT  one-hot read strobe
- slot_wr  out  N_SLOT  one-hot write strobe
- slot_reg_addr  out  REG_W  register index, broadcast to all slots
- slot_wr_data  out  32  write data, broadcast to all slots
- slot_rd_data  in  N_SLOT*32  slot s read data at [s*32 +: 32]
- slot_ready  in  N_SLOT  per-slot completion
- err_cnt  out  8  saturating error count

## Operation
- Decode: reg = addr[REG_W-1:0]; slot = addr[REG_W +: SLOT_W].
- Decode error: any addr bit above REG_W+SLOT_W is set, or slot ≥ N_SLOT.
- A request is mmio_cs & (mmio_rd | mmio_wr), sampled in IDLE only.
  - If mmio_rd and mmio_wr are both set, the request is a write.
  - Requests arriving while the controller is busy are ignored, with no side effects.
- On acceptance, the controller latches slot, reg, op and wr_data. slot_reg_addr and slot_wr_data hold these values until the next accepted request.
- FSM states:
  - IDLE: on a valid request go to STRB; on a decode error go to RESP with err=1 and no strobe.
  - STRB: drive slot_cs[slot] and slot_rd[slot] or slot_wr[slot] high for exactly this cycle. If slot_ready[slot]=1, go to RESP; otherwise clear the wait counter and go to WAIT.
  - WAIT: all strobes are low. If slot_ready[slot]=1, go to RESP. Otherwise increment the counter; when the counter equals TO_CYC, go to RESP with err=1.
  - RESP: mmio_ready=1 for one cycle, then go to IDLE.
- slot_ready bits of non-selected slots are ignored.
- Read data:
  - On a read completed by ready, slot_rd_data for the selected slot is captured in the same edge that leaves STRB/WAIT.
  - On an errored read, ERR_DATA is loaded instead.
  - Writes never change mmio_rd_data, which otherwise holds its last value.
- err_cnt increments by 1 on each error response and saturates at 255.

## Timing
- Reset values: mmio_rd_data 0, mmio_ready 0, mmio_err 0, all slot strobes 0, slot_reg_addr 0, slot_wr_data 0, err_cnt 0, state IDLE.
- Request accepted at edge E0 (counting from the IDLE state). The STRB cycle is E0..E1.
  - Zero-wait slot (ready during STRB): mmio_ready is high during E1..E2, a latency of 2 cycles.
  - Slot ready after k WAIT cycles: mmio_ready is high 2+k cycles after E0.
  - Timeout: mmio_ready and mmio_err are high 2+TO_CYC cycles after E0.
  - Decode error: mmio_ready and mmio_err are high 1 cycle after E0.
- mmio_rd_data is valid in the mmio_ready cycle and is stable until the next read response.
- The minimum request spacing is the previous mmio_ready cycle plus one. A request presented during the RESP cycle is ignored.
- slot_ready asserted at the exact timeout cycle takes priority: the access completes normally with err=0.
- Reset asserted mid-access forces IDLE asynchronously: strobes drop immediately and no mmio_ready is issued.

## Test plan
- Zero-wait read: slot 3 holds 32'hCAFE_0003 with ready tied high; read addr 0x064 (slot 3, reg 4) -> one strobe cycle on slot_cs[3]/slot_rd[3], slot_reg_addr=4, mmio_ready 2 cycles later, rd_data=32'hCAFE_0003, err=0.
- Wait states: write 32'h1234_5678 to slot 9 reg 0 while slot 9 raises ready 5 cycles after its strobe -> slot_wr[9] high for 1 cycle, slot_wr_data=32'h1234_5678, mmio_ready at cycle 7, rd_data unchanged.
- Timeout: read slot 10 with its ready held low and TO_CYC=8 -> mmio_ready+mmio_err at cycle 10, rd_data=ERR_DATA, err_cnt=1. Ready arriving exactly at cycle 8 of WAIT -> normal completion.
- Decode error: N_SLOT=16, read addr 0x200 -> no strobes, mmio_ready+err 1 cycle later. Repeating this 300 times -> err_cnt saturates at 255.
- Busy rejection: issue a second request during WAIT and during RESP -> no second strobe and no state change; the first access completes normally.
- Reset mid-WAIT: assert reset 3 cycles into WAIT -> all outputs return to their reset values immediately; the next request after release completes with 2-cycle latency.
